// File: rtl/mole_game_pkg.sv
// Shared types and helpers for the whack-a-mole game engine.
package mole_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        UP,
        COOLDOWN,
        OVER
    } game_state_e;

    // Galois feedback masks giving maximal-length sequences for common widths.
    function automatic int default_taps(input int width);
        case (width)
            4:       return 'h9;
            5:       return 'h12;
            6:       return 'h21;
            7:       return 'h41;
            8:       return 'hB8;
            12:      return 'hE08;
            16:      return 'hB400;
            default: return 'hB8;
        endcase
    endfunction

    // Show period shrinks linearly with level and is clamped at a floor.
    function automatic int period_for_level(input int lvl, input int base,
                                            input int step, input int floor_p);
        int p;
        p = base - lvl * step;
        if (p < floor_p) p = floor_p;
        return p;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Galois LFSR used to pick the next mole; a zero seed is forced to 1 so the
// register can never lock up in the all-zero state.
module mole_lfsr
    import mole_game_pkg::*;
#(
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(default_taps(LFSR_W))
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_enable,
    output logic [LFSR_W-1:0] o_value
);

    logic [LFSR_W-1:0] r_state;

    // Load takes priority over stepping; each step shifts right and folds in the taps.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= LFSR_W'(1);
        end else if (i_load) begin
            r_state <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
        end else if (i_enable) begin
            r_state <= r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);
        end
    end

    assign o_value = r_state;

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole game engine: mole selection, show/cooldown timing, hit/miss
// scoring, lives and level progression. All outputs are registered.
module mole_game_core
    import mole_game_pkg::*;
#(
    parameter int                NUM_MOLES      = 4,
    parameter int                LFSR_W         = 8,
    parameter logic [LFSR_W-1:0] TAPS           = LFSR_W'(default_taps(LFSR_W)),
    parameter int                TIMER_W        = 28,
    parameter int                BASE_PERIOD    = 50000000,
    parameter int                PERIOD_STEP    = 10000000,
    parameter int                MIN_PERIOD     = 10000000,
    parameter int                COOL_CYCLES    = 5000000,
    parameter int                HITS_PER_LEVEL = 8,
    parameter int                NUM_LEVELS     = 4,
    parameter int                LIVES          = 3,
    parameter int                SCORE_W        = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [LFSR_W-1:0]             seed,
    input  logic [NUM_MOLES-1:0]          buttons,
    output logic [NUM_MOLES-1:0]          moles,
    output logic [SCORE_W-1:0]            score,
    output logic [$clog2(NUM_LEVELS)-1:0] level,
    output logic [3:0]                    lives,
    output logic                          game_over,
    output logic                          hit_pulse,
    output logic                          miss_pulse
);

    localparam int IDX_W  = $clog2(NUM_MOLES);
    localparam int LVL_W  = $clog2(NUM_LEVELS);
    localparam int HCNT_W = $clog2(HITS_PER_LEVEL + 1);

    game_state_e          r_state;
    game_state_e          w_nextState;
    logic [NUM_MOLES-1:0] r_buttonsQ;
    logic [NUM_MOLES-1:0] w_edges;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_period;
    logic [IDX_W-1:0]     r_prevIdx;
    logic                 r_prevValid;
    logic [HCNT_W-1:0]    r_hitCnt;
    logic [LFSR_W-1:0]    w_lfsr;
    logic [IDX_W-1:0]     w_rawIdx;
    logic [IDX_W-1:0]     w_spawnIdx;
    logic                 w_init;
    logic                 w_hit;
    logic                 w_miss;

    mole_lfsr #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_lfsr (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_init),
        .i_seed   (seed),
        .i_enable (r_state == SPAWN),
        .o_value  (w_lfsr)
    );

    assign w_edges  = buttons & ~r_buttonsQ;
    assign w_period = TIMER_W'(period_for_level(int'(level), BASE_PERIOD, PERIOD_STEP, MIN_PERIOD));
    assign w_rawIdx = IDX_W'(32'(w_lfsr) % 32'(NUM_MOLES));

    // Never show the same mole twice in a row: a repeat is bumped to the next mole.
    assign w_spawnIdx = (r_prevValid && (w_rawIdx == r_prevIdx))
                      ? ((w_rawIdx == IDX_W'(NUM_MOLES - 1)) ? '0 : w_rawIdx + IDX_W'(1))
                      : w_rawIdx;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Next state plus hit/miss decode; a hit outranks a wrong press and the timeout.
    always_comb begin
        w_nextState = r_state;
        w_init      = 1'b0;
        w_hit       = 1'b0;
        w_miss      = 1'b0;
        case (r_state)
            IDLE, OVER: begin
                if (start) begin
                    w_init      = 1'b1;
                    w_nextState = SPAWN;
                end
            end
            SPAWN: w_nextState = UP;
            UP: begin
                if (w_edges[r_prevIdx]) begin
                    w_hit = 1'b1;
                end else if ((w_edges != '0) || (r_timer == TIMER_W'(1))) begin
                    w_miss = 1'b1;
                end
                if (w_hit || w_miss) w_nextState = COOLDOWN;
            end
            COOLDOWN: begin
                if (r_timer == TIMER_W'(1)) w_nextState = (lives == 4'd0) ? OVER : SPAWN;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Game datapath: shared timer, lit mole, score/level/lives and the one-cycle pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_buttonsQ  <= '0;
            r_timer     <= '0;
            r_prevIdx   <= '0;
            r_prevValid <= 1'b0;
            r_hitCnt    <= '0;
            moles       <= '0;
            score       <= '0;
            level       <= '0;
            lives       <= 4'd0;
            game_over   <= 1'b0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
        end else begin
            r_buttonsQ <= buttons;
            hit_pulse  <= w_hit;
            miss_pulse <= w_miss;
            case (r_state)
                IDLE, OVER: begin
                    if (w_init) begin
                        score       <= '0;
                        level       <= '0;
                        lives       <= 4'(LIVES);
                        r_hitCnt    <= '0;
                        r_prevValid <= 1'b0;
                        game_over   <= 1'b0;
                    end
                end
                SPAWN: begin
                    moles       <= NUM_MOLES'(1) << w_spawnIdx;
                    r_timer     <= w_period;
                    r_prevIdx   <= w_spawnIdx;
                    r_prevValid <= 1'b1;
                end
                UP: begin
                    if (w_hit) begin
                        moles   <= '0;
                        r_timer <= TIMER_W'(COOL_CYCLES);
                        if (score != '1) score <= score + SCORE_W'(1);
                        if (r_hitCnt == HCNT_W'(HITS_PER_LEVEL - 1)) begin
                            r_hitCnt <= '0;
                            if (level != LVL_W'(NUM_LEVELS - 1)) level <= level + LVL_W'(1);
                        end else begin
                            r_hitCnt <= r_hitCnt + HCNT_W'(1);
                        end
                    end else if (w_miss) begin
                        moles   <= '0;
                        r_timer <= TIMER_W'(COOL_CYCLES);
                        lives   <= lives - 4'd1;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                COOLDOWN: begin
                    if (r_timer == TIMER_W'(1)) begin
                        if (lives == 4'd0) game_over <= 1'b1;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_game_core.sv
// Self-checking bench for mole_game_core with a round-level reference model.
module tb_mole_game_core;

    localparam int A_HIT     = 0;
    localparam int A_TIMEOUT = 1;
    localparam int A_WRONG   = 2;
    localparam int A_BOTH    = 3;
    localparam int A_HOLD    = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] seed  = 8'h00;
    logic [3:0] buttons = 4'h0;
    logic [3:0] moles;
    logic [7:0] score;
    logic [1:0] level;
    logic [3:0] lives;
    logic       game_over;
    logic       hit_pulse;
    logic       miss_pulse;

    int nCompared = 0;
    int nMismatch = 0;
    int nReroll   = 0;

    int mLfsr, mPrev, mScore, mLevel, mLives, mHitCnt;
    bit mPrevValid;
    int seqCur[$];
    int seqB[$];

    mole_game_core #(
        .NUM_MOLES      (4),
        .LFSR_W         (8),
        .TAPS           (8'hB8),
        .TIMER_W        (28),
        .BASE_PERIOD    (20),
        .PERIOD_STEP    (4),
        .MIN_PERIOD     (8),
        .COOL_CYCLES    (2),
        .HITS_PER_LEVEL (2),
        .NUM_LEVELS     (4),
        .LIVES          (3),
        .SCORE_W        (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .seed       (seed),
        .buttons    (buttons),
        .moles      (moles),
        .score      (score),
        .level      (level),
        .lives      (lives),
        .game_over  (game_over),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Last-resort guard so the run can never hang.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int lfsrNext(input int x);
        return (x % 2 == 1) ? ((x / 2) ^ 'hB8) : (x / 2);
    endfunction

    function automatic int periodOf(input int lvl);
        int p;
        p = 20 - 4 * lvl;
        return (p < 8) ? 8 : p;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelStart(input int s);
        mLfsr      = (s == 0) ? 1 : s;
        mPrevValid = 0;
        mPrev      = 0;
        mScore     = 0;
        mLevel     = 0;
        mLives     = 3;
        mHitCnt    = 0;
    endtask

    task automatic modelHit();
        if (mScore < 255) mScore++;
        mHitCnt++;
        if (mHitCnt == 2) begin
            mHitCnt = 0;
            if (mLevel < 3) mLevel++;
        end
    endtask

    task automatic startGame(input int s);
        buttons = 4'h0;
        seed    = 8'(s);
        start   = 1'b1;
        step();
        start = 1'b0;
        modelStart(s);
        checkOutput("start_lives", int'(lives), 3);
        checkOutput("start_score", int'(score), 0);
        checkOutput("start_level", int'(level), 0);
        checkOutput("start_over", int'(game_over), 0);
    endtask

    // One mole: predict it, wait for it, act on it, then check the game registers.
    task automatic applyStimulus(input int action, input int delay);
        int idx, other, expPeriod, n, lit, extra;
        idx = mLfsr % 4;
        if (mPrevValid && idx == mPrev) begin
            idx = (idx + 1) % 4;
            nReroll++;
        end
        mPrev      = idx;
        mPrevValid = 1;
        mLfsr      = lfsrNext(mLfsr);
        expPeriod  = periodOf(mLevel);
        seqCur.push_back(idx);
        n = 0;
        while (moles == 4'h0 && n < 100) begin
            step();
            n++;
        end
        checkOutput("mole_lit", int'(moles), 1 << idx);
        other = (idx + 1 + int'($urandom_range(0, 2))) % 4;
        case (action)
            A_TIMEOUT: begin
                lit = 0;
                while (moles != 4'h0 && lit < 64) begin
                    lit++;
                    step();
                end
                checkOutput("show_cycles", lit, expPeriod);
                checkOutput("timeout_miss_pulse", int'(miss_pulse), 1);
                mLives--;
            end
            A_WRONG: begin
                buttons = 4'(1 << other);
                step();
                checkOutput("wrong_miss_pulse", int'(miss_pulse), 1);
                checkOutput("wrong_no_hit", int'(hit_pulse), 0);
                checkOutput("wrong_moles_dark", int'(moles), 0);
                mLives--;
            end
            default: begin
                repeat (delay) step();
                buttons = 4'(1 << idx);
                if (action == A_BOTH) buttons = buttons | 4'(1 << other);
                step();
                checkOutput("hit_pulse", int'(hit_pulse), 1);
                checkOutput("hit_no_miss", int'(miss_pulse), 0);
                checkOutput("hit_moles_dark", int'(moles), 0);
                modelHit();
                if (action == A_HOLD) begin
                    extra = 0;
                    repeat (9) begin
                        step();
                        if (hit_pulse) extra++;
                    end
                    checkOutput("hold_extra_pulses", extra, 0);
                end
            end
        endcase
        checkOutput("score", int'(score), mScore);
        checkOutput("level", int'(level), mLevel);
        checkOutput("lives", int'(lives), mLives);
        buttons = 4'h0;
        step();
        checkOutput("pulses_clear", int'(hit_pulse | miss_pulse), 0);
    endtask

    task automatic expectGameOver();
        int n;
        n = 0;
        while (!game_over && n < 20) begin
            step();
            n++;
        end
        checkOutput("game_over", int'(game_over), 1);
        checkOutput("over_moles", int'(moles), 0);
        checkOutput("over_lives", int'(lives), 0);
        repeat (5) step();
        checkOutput("over_score_frozen", int'(score), mScore);
        checkOutput("over_level_frozen", int'(level), mLevel);
    endtask

    task automatic scriptB();
        applyStimulus(A_HOLD, 0);
        applyStimulus(A_HIT, 0);
        applyStimulus(A_TIMEOUT, 0);
        applyStimulus(A_BOTH, 1);
        applyStimulus(A_HIT, 15);
        applyStimulus(A_HIT, 3);
        applyStimulus(A_HIT, 0);
        applyStimulus(A_TIMEOUT, 0);
        applyStimulus(A_HIT, 2);
        applyStimulus(A_BOTH, 0);
        applyStimulus(A_WRONG, 1);
        expectGameOver();
    endtask

    // Directed sequence of games, ending with a long randomized run to saturate the score.
    initial begin
        int n, lit;
        $display("[TB] starting mole_game_core bench");
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checkOutput("rst_moles", int'(moles), 0);
        checkOutput("rst_score", int'(score), 0);
        checkOutput("rst_level", int'(level), 0);
        checkOutput("rst_lives", int'(lives), 0);
        checkOutput("rst_over", int'(game_over), 0);
        checkOutput("rst_pulses", int'(hit_pulse | miss_pulse), 0);

        // Zero seed behaves as seed 1; three timeouts end the game.
        startGame(0);
        applyStimulus(A_TIMEOUT, 0);
        applyStimulus(A_TIMEOUT, 0);
        applyStimulus(A_TIMEOUT, 0);
        expectGameOver();

        // Seed 5A played twice must give the same mole sequence.
        seqCur.delete();
        startGame('h5A);
        scriptB();
        seqB = seqCur;
        seqCur.delete();
        startGame('h5A);
        scriptB();
        checkOutput("replay_len", seqCur.size(), seqB.size());
        for (int i = 0; i < seqB.size() && i < seqCur.size(); i++)
            checkOutput("replay_mole", seqCur[i], seqB[i]);

        // Reset held mid-show returns everything to idle.
        startGame(int'($urandom_range(1, 255)));
        applyStimulus(A_HIT, 1);
        n = 0;
        while (moles == 4'h0 && n < 50) begin
            step();
            n++;
        end
        checkOutput("pre_reset_lit", int'(moles != 4'h0), 1);
        reset = 1'b1;
        step();
        checkOutput("midrst_moles", int'(moles), 0);
        checkOutput("midrst_score", int'(score), 0);
        checkOutput("midrst_lives", int'(lives), 0);
        step();
        step();
        reset = 1'b0;
        lit = 0;
        repeat (30) begin
            step();
            if (moles != 4'h0 || game_over) lit++;
        end
        checkOutput("idle_after_reset", lit, 0);

        // Long randomized game with start held high; score must saturate at 255.
        startGame(int'($urandom_range(0, 255)));
        start = 1'b1;
        for (int r = 0; r < 258; r++) begin
            applyStimulus(($urandom_range(0, 1) == 0) ? A_HIT : A_BOTH,
                          int'($urandom_range(0, periodOf(mLevel) - 1)));
        end
        start = 1'b0;
        checkOutput("score_saturated", int'(score), 255);
        checkOutput("level_capped", int'(level), 3);
        checkOutput("reroll_seen", int'(nReroll > 0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
